// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: enable/flush/bubble sequencer for the 5-stage pipeline.
// Handles load-use stalls, taken-branch squashes and data-memory waits with timeout.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic memstall;
    logic load_use;
    logic freeze;
    logic eval;

    assign memstall = mem_req & ~mem_ready;
    assign load_use = idex_memread & (idex_rt != 5'd0) &
                      ((idex_rt == ifid_rs) |
                       (ifid_uses_rt & (idex_rt == ifid_rt)));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        freeze  = 1'b0;
        eval    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (memstall) begin
                    freeze  = 1'b1;
                    state_d = S_WAIT;
                    wait_d  = WW'(1);
                end else begin
                    eval = 1'b1;
                end
            end
            S_WAIT: begin
                // Ready wins over a timeout landing in the same cycle.
                if (mem_ready) begin
                    eval    = 1'b1;
                    state_d = S_RUN;
                    wait_d  = '0;
                end else if (wait_q < WAIT_MAX) begin
                    freeze = 1'b1;
                    wait_d = wait_q + WW'(1);
                end else begin
                    freeze  = 1'b1;
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_ERR: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = S_RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_en      = 1'b0;
            idex_flush   = 1'b1;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (eval) begin
            // A taken branch squashes ID, so a coincident load-use is moot.
            if (branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    assign cnt_d = (!pc_en && (cnt_q != {CNT_W{1'b1}}))
                 ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_err   = err_q;
    assign stall_cnt = cnt_q;

endmodule
